// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/forwarding unit
package hazard_pkg;

  localparam int FWD_RF   = 0;
  // Tracked destinations are stored zero-extended so one entry type serves any RA_W up to this width.
  localparam int RA_W_MAX = 8;

  typedef struct packed {
    logic                v;
    logic                we;
    logic [RA_W_MAX-1:0] dst;
    logic                ld;
  } entry_t;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// rtl/hazard_fwd_unit_if.sv - decode-side bundle between decode and the hazard/forwarding unit
interface hazard_fwd_unit_if #(
  parameter int RA_W  = 5,
  parameter int SEL_W = 2
);

  logic            id_valid;
  logic [RA_W-1:0] id_src_a;
  logic [RA_W-1:0] id_src_b;
  logic            id_use_a;
  logic            id_use_b;
  logic [RA_W-1:0] id_dst;
  logic            id_we;
  logic            id_load;
  logic            flush;

  logic [SEL_W-1:0] fwd_sel_a;
  logic [SEL_W-1:0] fwd_sel_b;
  logic             stall;
  logic [15:0]      stall_cnt;

  modport master (
    output id_valid, id_src_a, id_src_b, id_use_a, id_use_b,
    output id_dst, id_we, id_load, flush,
    input  fwd_sel_a, fwd_sel_b, stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_src_a, id_src_b, id_use_a, id_use_b,
    input  id_dst, id_we, id_load, flush,
    output fwd_sel_a, fwd_sel_b, stall, stall_cnt
  );

endinterface

// File: rtl/hazard_fwd_unit_fwd_match.sv
// rtl/hazard_fwd_unit_fwd_match.sv - per-operand producer scan: forward select and load-hit flag
module fwd_match
  import hazard_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = 2
) (
  input  entry_t [STAGES:1]   ents,
  input  logic [RA_W_MAX-1:0] src,
  input  logic                use_src,
  input  logic                valid,
  output logic [SEL_W-1:0]    sel,
  output logic                load_hit
);

  // Oldest to youngest so the last assignment left standing is the nearest producer.
  always_comb begin
    sel      = SEL_W'(FWD_RF);
    load_hit = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (ents[k].v && ents[k].we && (ents[k].dst == src) &&
          (src != '0) && use_src && valid) begin
        sel = SEL_W'(k);
        if (ents[k].ld && (k <= LOAD_LAT)) begin
          load_hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - tracks in-flight destinations, drives bypass selects and load-use stall
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int  RA_W     = 5,
  parameter int  STAGES   = 3,
  parameter int  LOAD_LAT = 1,
  localparam int SEL_W    = $clog2(STAGES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  hazard_fwd_unit_if.slave   bus
);

  entry_t [STAGES:1]   pipe;
  entry_t              new_ent;
  logic [RA_W_MAX-1:0] src_a;
  logic [RA_W_MAX-1:0] src_b;
  logic [SEL_W-1:0]    sel_a;
  logic [SEL_W-1:0]    sel_b;
  logic                hit_a;
  logic                hit_b;
  logic                stall;
  logic [15:0]         cnt_q;

  assign src_a = RA_W_MAX'(bus.id_src_a);
  assign src_b = RA_W_MAX'(bus.id_src_b);

  fwd_match #(
    .STAGES   (STAGES),
    .LOAD_LAT (LOAD_LAT),
    .SEL_W    (SEL_W)
  ) u_match_a (
    .ents     (pipe),
    .src      (src_a),
    .use_src  (bus.id_use_a),
    .valid    (bus.id_valid),
    .sel      (sel_a),
    .load_hit (hit_a)
  );

  fwd_match #(
    .STAGES   (STAGES),
    .LOAD_LAT (LOAD_LAT),
    .SEL_W    (SEL_W)
  ) u_match_b (
    .ents     (pipe),
    .src      (src_b),
    .use_src  (bus.id_use_b),
    .valid    (bus.id_valid),
    .sel      (sel_b),
    .load_hit (hit_b)
  );

  // A squashed decode instruction cannot be waiting on anything.
  assign stall = (hit_a || hit_b) && !bus.flush;

  always_comb begin
    new_ent = '0;
    if (bus.id_valid && !stall && !bus.flush) begin
      new_ent.v   = 1'b1;
      new_ent.we  = bus.id_we;
      new_ent.dst = RA_W_MAX'(bus.id_dst);
      new_ent.ld  = bus.id_load;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe  <= '0;
      cnt_q <= '0;
    end else begin
      pipe <= {pipe[STAGES-1:1], new_ent};
      if (stall && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign bus.fwd_sel_a = sel_a;
  assign bus.fwd_sel_b = sel_b;
  assign bus.stall     = stall;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed vectors and reference-model sweep for hazard_fwd_unit
module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_r;

  typedef struct packed {
    logic       valid;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       use_a;
    logic       use_b;
    logic [4:0] dst;
    logic       we;
    logic       load;
    logic       flush;
  } stim_t;

  typedef struct {
    stim_t s;
    int    sel_a;
    int    sel_b;
    int    stall;
    int    cnt;
  } vec_t;

  typedef struct packed {
    logic       v;
    logic       we;
    logic       ld;
    logic [4:0] dst;
  } ment_t;
  typedef ment_t [7:1] mpipe_t;

  stim_t sa, sb, sr;

  hazard_fwd_unit_if #(.RA_W(5), .SEL_W(2)) if_a ();
  hazard_fwd_unit_if #(.RA_W(5), .SEL_W(2)) if_b ();
  hazard_fwd_unit_if #(.RA_W(5), .SEL_W(2)) if_2 ();
  hazard_fwd_unit_if #(.RA_W(5), .SEL_W(3)) if_7 ();

  assign if_a.id_valid = sa.valid;  assign if_a.id_src_a = sa.src_a;  assign if_a.id_src_b = sa.src_b;
  assign if_a.id_use_a = sa.use_a;  assign if_a.id_use_b = sa.use_b;  assign if_a.id_dst = sa.dst;
  assign if_a.id_we = sa.we;        assign if_a.id_load = sa.load;    assign if_a.flush = sa.flush;

  assign if_b.id_valid = sb.valid;  assign if_b.id_src_a = sb.src_a;  assign if_b.id_src_b = sb.src_b;
  assign if_b.id_use_a = sb.use_a;  assign if_b.id_use_b = sb.use_b;  assign if_b.id_dst = sb.dst;
  assign if_b.id_we = sb.we;        assign if_b.id_load = sb.load;    assign if_b.flush = sb.flush;

  assign if_2.id_valid = sr.valid;  assign if_2.id_src_a = sr.src_a;  assign if_2.id_src_b = sr.src_b;
  assign if_2.id_use_a = sr.use_a;  assign if_2.id_use_b = sr.use_b;  assign if_2.id_dst = sr.dst;
  assign if_2.id_we = sr.we;        assign if_2.id_load = sr.load;    assign if_2.flush = sr.flush;

  assign if_7.id_valid = sr.valid;  assign if_7.id_src_a = sr.src_a;  assign if_7.id_src_b = sr.src_b;
  assign if_7.id_use_a = sr.use_a;  assign if_7.id_use_b = sr.use_b;  assign if_7.id_dst = sr.dst;
  assign if_7.id_we = sr.we;        assign if_7.id_load = sr.load;    assign if_7.flush = sr.flush;

  hazard_fwd_unit #(.RA_W(5), .STAGES(3), .LOAD_LAT(1)) dut_a (.clk(clk), .reset(rst_a), .bus(if_a.slave));
  hazard_fwd_unit #(.RA_W(5), .STAGES(3), .LOAD_LAT(2)) dut_b (.clk(clk), .reset(rst_b), .bus(if_b.slave));
  hazard_fwd_unit #(.RA_W(5), .STAGES(2), .LOAD_LAT(1)) dut_2 (.clk(clk), .reset(rst_r), .bus(if_2.slave));
  hazard_fwd_unit #(.RA_W(5), .STAGES(7), .LOAD_LAT(6)) dut_7 (.clk(clk), .reset(rst_r), .bus(if_7.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic v, input int a, input int b, input logic ua, input logic ub,
                               input int d, input logic we, input logic ld, input logic fl);
    stim_t m;
    m.valid = v;      m.src_a = 5'(a); m.src_b = 5'(b);
    m.use_a = ua;     m.use_b = ub;    m.dst = 5'(d);
    m.we = we;        m.load = ld;     m.flush = fl;
    return m;
  endfunction

  // Reference: scan nearest-first; any matching load inside the latency window stalls.
  function automatic void model_eval(input mpipe_t p, input int depth, input int lat, input stim_t s,
                                     output int ea, output int eb, output int es);
    logic hit;
    ea = 0; eb = 0; hit = 1'b0;
    for (int k = 1; k <= depth; k++) begin
      if (s.valid && p[k].v && p[k].we && p[k].dst != 5'd0) begin
        if (s.use_a && p[k].dst == s.src_a) begin
          if (ea == 0) ea = k;
          if (p[k].ld && k <= lat) hit = 1'b1;
        end
        if (s.use_b && p[k].dst == s.src_b) begin
          if (eb == 0) eb = k;
          if (p[k].ld && k <= lat) hit = 1'b1;
        end
      end
    end
    es = (hit && !s.flush) ? 1 : 0;
  endfunction

  function automatic mpipe_t model_step(input mpipe_t p, input stim_t s, input int es);
    mpipe_t q;
    q = p << $bits(ment_t);
    if (s.valid && es == 0 && !s.flush) begin
      q[1].v = 1'b1; q[1].we = s.we; q[1].ld = s.load; q[1].dst = s.dst;
    end
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t   vt[16];
  mpipe_t m2, m7;
  int     c2, c7, total7, ea, eb, es, cyc;

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // STAGES=3, LOAD_LAT=1 vectors: {valid,srcA,srcB,useA,useB,dst,we,ld,flush} -> sel_a, sel_b, stall, stall_cnt
    vt[0]  = '{mk(0, 3, 3, 1, 1, 0, 0, 0, 0), 0, 0, 0, 0};
    vt[1]  = '{mk(1, 1, 2, 1, 1, 3, 1, 0, 0), 0, 0, 0, 0};
    vt[2]  = '{mk(1, 3, 4, 1, 1, 6, 1, 0, 0), 1, 0, 0, 0};
    vt[3]  = '{mk(1, 3, 6, 1, 1, 8, 1, 0, 0), 2, 1, 0, 0};
    vt[4]  = '{mk(1, 3, 8, 1, 1, 0, 1, 0, 0), 3, 1, 0, 0};
    vt[5]  = '{mk(1, 0, 6, 1, 1, 5, 1, 0, 0), 0, 3, 0, 0};
    vt[6]  = '{mk(1, 8, 5, 0, 1, 5, 0, 0, 0), 0, 1, 0, 0};
    vt[7]  = '{mk(1, 5, 9, 1, 1, 5, 1, 0, 0), 2, 0, 0, 0};
    vt[8]  = '{mk(1, 1, 5, 1, 1, 10, 1, 0, 0), 0, 1, 0, 0};
    vt[9]  = '{mk(1, 10, 2, 1, 1, 7, 1, 1, 0), 1, 0, 0, 0};
    vt[10] = '{mk(1, 7, 2, 1, 1, 11, 1, 0, 0), 1, 0, 1, 0};
    vt[11] = '{mk(1, 7, 2, 1, 1, 11, 1, 0, 0), 2, 0, 0, 1};
    vt[12] = '{mk(1, 7, 2, 1, 1, 12, 1, 1, 0), 3, 0, 0, 1};
    vt[13] = '{mk(1, 1, 12, 1, 1, 13, 1, 0, 1), 0, 1, 0, 1};
    vt[14] = '{mk(0, 11, 2, 1, 1, 14, 1, 0, 0), 0, 0, 0, 1};
    vt[15] = '{mk(1, 12, 12, 1, 1, 0, 0, 0, 0), 3, 3, 0, 1};

    sa = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    sb = sa;
    sr = sa;
    rst_a = 1'b0; rst_b = 1'b0; rst_r = 1'b0;
    tick();
    tick();
    rst_a = 1'b1; rst_b = 1'b1; rst_r = 1'b1;

    for (int i = 0; i < 16; i++) begin
      sa = vt[i].s;
      @(negedge clk);
      chk($sformatf("vec%0d sel_a", i), int'(if_a.fwd_sel_a), vt[i].sel_a);
      chk($sformatf("vec%0d sel_b", i), int'(if_a.fwd_sel_b), vt[i].sel_b);
      chk($sformatf("vec%0d stall", i), int'(if_a.stall), vt[i].stall);
      chk($sformatf("vec%0d stall_cnt", i), int'(if_a.stall_cnt), vt[i].cnt);
      tick();
    end

    // Reset during a load-use stall
    sa = mk(1, 1, 2, 1, 1, 7, 1, 1, 0);
    tick();
    sa = mk(1, 7, 2, 1, 0, 9, 1, 0, 0);
    @(negedge clk);
    chk("rst_mid pre stall", int'(if_a.stall), 1);
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    @(negedge clk);
    chk("rst_mid stall", int'(if_a.stall), 0);
    chk("rst_mid stall_cnt", int'(if_a.stall_cnt), 0);
    chk("rst_mid sel_a", int'(if_a.fwd_sel_a), 0);
    tick();

    // LOAD_LAT=2: distance 1 stalls twice, distance 2 stalls once
    sb = mk(1, 1, 2, 1, 1, 7, 1, 1, 0);
    @(negedge clk); chk("lat2 load stall", int'(if_b.stall), 0);
    tick();
    sb = mk(1, 7, 2, 1, 0, 9, 1, 0, 0);
    @(negedge clk); chk("lat2 d1 c1 stall", int'(if_b.stall), 1); chk("lat2 d1 c1 sel_a", int'(if_b.fwd_sel_a), 1);
    tick();
    @(negedge clk); chk("lat2 d1 c2 stall", int'(if_b.stall), 1); chk("lat2 d1 c2 sel_a", int'(if_b.fwd_sel_a), 2);
    chk("lat2 d1 c2 cnt", int'(if_b.stall_cnt), 1);
    tick();
    @(negedge clk); chk("lat2 d1 c3 stall", int'(if_b.stall), 0); chk("lat2 d1 c3 sel_a", int'(if_b.fwd_sel_a), 3);
    chk("lat2 d1 c3 cnt", int'(if_b.stall_cnt), 2);
    tick();
    sb = mk(1, 1, 2, 1, 1, 7, 1, 1, 0);
    @(negedge clk); chk("lat2 d2 load stall", int'(if_b.stall), 0);
    tick();
    sb = mk(1, 1, 2, 1, 1, 10, 1, 0, 0);
    tick();
    sb = mk(1, 7, 2, 1, 0, 9, 1, 0, 0);
    @(negedge clk); chk("lat2 d2 c1 stall", int'(if_b.stall), 1); chk("lat2 d2 c1 sel_a", int'(if_b.fwd_sel_a), 2);
    tick();
    @(negedge clk); chk("lat2 d2 c2 stall", int'(if_b.stall), 0); chk("lat2 d2 c2 sel_a", int'(if_b.fwd_sel_a), 3);
    chk("lat2 d2 c2 cnt", int'(if_b.stall_cnt), 3);
    tick();

    // Random streams on STAGES=2 and STAGES=7 against the reference model
    m2 = '0; m7 = '0; c2 = 0; c7 = 0;
    for (int c = 0; c < 400; c++) begin
      sr = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      @(negedge clk);
      model_eval(m2, 2, 1, sr, ea, eb, es);
      chk($sformatf("rnd2 c%0d sel_a", c), int'(if_2.fwd_sel_a), ea);
      chk($sformatf("rnd2 c%0d sel_b", c), int'(if_2.fwd_sel_b), eb);
      chk($sformatf("rnd2 c%0d stall", c), int'(if_2.stall), es);
      chk($sformatf("rnd2 c%0d cnt", c), int'(if_2.stall_cnt), c2);
      m2 = model_step(m2, sr, es);
      if (es != 0) c2++;
      model_eval(m7, 7, 6, sr, ea, eb, es);
      chk($sformatf("rnd7 c%0d sel_a", c), int'(if_7.fwd_sel_a), ea);
      chk($sformatf("rnd7 c%0d sel_b", c), int'(if_7.fwd_sel_b), eb);
      chk($sformatf("rnd7 c%0d stall", c), int'(if_7.stall), es);
      chk($sformatf("rnd7 c%0d cnt", c), int'(if_7.stall_cnt), c7);
      m7 = model_step(m7, sr, es);
      if (es != 0) c7++;
      tick();
    end

    // Saturation: a self-dependent load keeps the 7-stage unit stalled 6 of every 7 cycles
    rst_r = 1'b0;
    tick();
    rst_r = 1'b1;
    m2 = '0; m7 = '0; c2 = 0; c7 = 0; total7 = 0; cyc = 0;
    sr = mk(1, 7, 7, 1, 0, 7, 1, 1, 0);
    while (total7 < 65540 && cyc < 80000) begin
      model_eval(m2, 2, 1, sr, ea, eb, es);
      m2 = model_step(m2, sr, es);
      if (es != 0) c2++;
      model_eval(m7, 7, 6, sr, ea, eb, es);
      m7 = model_step(m7, sr, es);
      if (es != 0) begin
        total7++;
        if (c7 != 65535) c7++;
      end
      cyc++;
      tick();
    end
    @(negedge clk);
    chk("sat budget", int'(total7 >= 65540), 1);
    chk("sat stall_cnt s7", int'(if_7.stall_cnt), c7);
    chk("sat stall_cnt s7 ffff", int'(if_7.stall_cnt), 65535);
    chk("sat stall_cnt s2", int'(if_2.stall_cnt), c2);
    model_eval(m7, 7, 6, sr, ea, eb, es);
    chk("sat stall s7", int'(if_7.stall), es);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
